seq_det_ctrl: RTL

Stream controller for the serial pattern-detection datapath. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into a configurable pattern matcher. It latches the pattern configuration once per job and counts matches. It signals job completion to the host, so a bit-serial detector can be driven from a word-wide bus.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_match_core.sv | 52 +++++
 rtl/seq_det_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern-detection controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register, fill guard, masked
// compare against the active pattern bits, and optional history clear on a hit.
module seq_match_core #(
    parameter int unsigned PAT_MAX = 4,
    parameter int unsigned LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               bit_i,
    input  logic               bit_valid_i,
    input  logic [PAT_MAX-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_en_i,
    output logic               hit_c
);

    logic [PAT_MAX-1:0] hist_q, hist_d, hist_n, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;

    always_comb begin
        hist_n = PAT_MAX'({hist_q, bit_i});
        fill_n = (fill_q >= LEN_W'(PAT_MAX)) ? fill_q : fill_q + LEN_W'(1);
        mask   = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < 32'(len_i));
        end
        // Fill guard keeps reset/cleared zeros in the history from matching.
        hit_c  = bit_valid_i && (len_i != '0) && (fill_n >= len_i) &&
                 (((hist_n ^ pattern_i) & mask) == '0);
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid_i) begin
            hist_d = hist_n;
            fill_d = (hit_c && !overlap_en_i) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit stream controller: accepts words over valid/ready, shifts them
// MSB-first into the matcher, counts matches and reports job completion.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PAT_MAX = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               overlap_en,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    seq_state_t         state_q, state_d;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               job_start, bit_valid, hit;

    assign job_start = (state_q == IDLE) && start;
    assign bit_valid = (state_q == SHIFT);

    seq_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (job_start),
        .bit_i        (sreg_q[DATA_W-1]),
        .bit_valid_i  (bit_valid),
        .pattern_i    (pat_q),
        .len_i        (len_q),
        .overlap_en_i (ovl_q),
        .hit_c        (hit)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        last_d  = last_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = cfg_pattern;
                    len_d   = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
                    ovl_d   = overlap_en;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (s_valid && ready_q) begin
                    sreg_d  = s_data;
                    last_d  = s_last;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d  = sreg_q << 1;
                match_d = hit;
                if (hit && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    state_d = last_q ? DONE : WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flags are registered from the next state so they line up with it.
        ready_d = (state_d == WAIT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready     = ready_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
